// File: rtl/csr_access_unit.sv
// csr_access_unit
//   Initiator side of the CSR read/write port. Executes one Zicsr instruction
//   (CSRRW/RS/RC and the immediate forms) at a time. It reads the CSR, computes
//   the read-modify-write value, issues a single-cycle write, and returns the
//   old CSR value for rd write-back. If trap entry is signalled while the
//   access is still in flight, the access is dropped.
//
// Ports
//   clk_sys_i, rst_sys_i           clock, asynchronous active-high reset
//   req_valid_i / req_ready_o      request handshake from execute
//   funct3_i, csr_addr_i           instruction fields
//   rs1_addr_i, rs1_data_i         rs1 index (uimm for I-forms) and value
//   rd_addr_i                      destination GPR index
//   pause_i, trap_enter_i          pipeline stall, trap entry (trap wins)
//   csr_read_*                     read strobe/address, combinational read data
//   csr_write_*                    single-cycle write strobe/address/data
//   rsp_valid_o, rd_*_o            completion pulse and rd write-back
//   illegal_o                      illegal access, qualified by rsp_valid_o
//   busy_o                         an instruction is in flight
module csr_access_unit #(
    parameter int unsigned REG_WIDTH = 64
) (
    input  logic                 clk_sys_i,
    input  logic                 rst_sys_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [2:0]           funct3_i,
    input  logic [11:0]          csr_addr_i,
    input  logic [4:0]           rs1_addr_i,
    input  logic [REG_WIDTH-1:0] rs1_data_i,
    input  logic [4:0]           rd_addr_i,
    input  logic                 pause_i,
    input  logic                 trap_enter_i,
    output logic                 csr_read_ena_o,
    output logic [11:0]          csr_read_addr_o,
    input  logic [REG_WIDTH-1:0] csr_read_data_i,
    output logic                 csr_write_ena_o,
    output logic [11:0]          csr_write_addr_o,
    output logic [REG_WIDTH-1:0] csr_write_data_o,
    output logic                 rsp_valid_o,
    output logic                 rd_we_o,
    output logic [4:0]           rd_addr_o,
    output logic [REG_WIDTH-1:0] rd_data_o,
    output logic                 illegal_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

    state_e                 state_q, state_d;
    logic [2:0]             funct3_q, funct3_d;
    logic [11:0]            addr_q, addr_d;
    logic [4:0]             rs1_addr_q, rs1_addr_d;
    logic [REG_WIDTH-1:0]   rs1_data_q, rs1_data_d;
    logic [4:0]             rd_addr_q, rd_addr_d;
    logic [REG_WIDTH-1:0]   old_q, old_d;
    logic [11:0]            wr_addr_q, wr_addr_d;
    logic [REG_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                   illegal_q, illegal_d;

    logic                   is_rw;
    logic                   read_supp;
    logic                   write_wanted;
    logic                   illegal_acc;
    logic [REG_WIDTH-1:0]   src;
    logic [REG_WIDTH-1:0]   old_val;
    logic [REG_WIDTH-1:0]   new_val;
    logic                   accept;
    logic                   clear_fields;

    // Decode of the latched instruction
    assign is_rw        = (funct3_q[1:0] == 2'b01);
    // CSRRW/RWI with rd==x0 must not cause read side effects
    assign read_supp    = is_rw && (rd_addr_q == 5'd0);
    // Set/clear forms with rs1==x0 (or uimm==0) never write
    assign write_wanted = is_rw || ((funct3_q[1:0] != 2'b00) && (rs1_addr_q != 5'd0));
    assign illegal_acc  = (funct3_q[1:0] == 2'b00) ||
                          (write_wanted && (addr_q[11:10] == 2'b11));
    assign src          = funct3_q[2] ? {{(REG_WIDTH-5){1'b0}}, rs1_addr_q} : rs1_data_q;
    assign old_val      = read_supp ? '0 : csr_read_data_i;

    always_comb begin
        new_val = '0;
        case (funct3_q[1:0])
            2'b01:   new_val = src;
            2'b10:   new_val = old_val | src;
            2'b11:   new_val = old_val & ~src;
            default: new_val = '0;
        endcase
    end

    // Reset is folded in so req_ready_o reads 0 while reset is held
    assign req_ready_o = (state_q == StIdle) && !pause_i && !trap_enter_i && !rst_sys_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_d      = state_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        rs1_addr_d   = rs1_addr_q;
        rs1_data_d   = rs1_data_q;
        rd_addr_d    = rd_addr_q;
        old_d        = old_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        illegal_d    = illegal_q;
        clear_fields = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    funct3_d   = funct3_i;
                    addr_d     = csr_addr_i;
                    rs1_addr_d = rs1_addr_i;
                    rs1_data_d = rs1_data_i;
                    rd_addr_d  = rd_addr_i;
                    state_d    = StRead;
                end
            end
            StRead: begin
                if (trap_enter_i) begin
                    clear_fields = 1'b1;
                    state_d      = StIdle;
                end else if (!pause_i) begin
                    old_d     = old_val;
                    wr_addr_d = addr_q;
                    wr_data_d = new_val;
                    illegal_d = illegal_acc;
                    state_d   = (write_wanted && !illegal_acc) ? StWrite : StResp;
                end
            end
            StWrite: begin
                if (trap_enter_i) begin
                    clear_fields = 1'b1;
                    state_d      = StIdle;
                end else if (!pause_i) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // The write already committed, so trap entry no longer cancels
                if (!pause_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear_fields) begin
            funct3_d   = '0;
            addr_d     = '0;
            rs1_addr_d = '0;
            rs1_data_d = '0;
            rd_addr_d  = '0;
            old_d      = '0;
            wr_addr_d  = '0;
            wr_data_d  = '0;
            illegal_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
        if (rst_sys_i) begin
            state_q    <= StIdle;
            funct3_q   <= '0;
            addr_q     <= '0;
            rs1_addr_q <= '0;
            rs1_data_q <= '0;
            rd_addr_q  <= '0;
            old_q      <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            rs1_addr_q <= rs1_addr_d;
            rs1_data_q <= rs1_data_d;
            rd_addr_q  <= rd_addr_d;
            old_q      <= old_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            illegal_q  <= illegal_d;
        end
    end

    assign csr_read_ena_o   = (state_q == StRead) && !read_supp;
    assign csr_read_addr_o  = (state_q == StRead) ? addr_q : 12'd0;
    assign csr_write_ena_o  = (state_q == StWrite) && !pause_i && !trap_enter_i;
    assign csr_write_addr_o = wr_addr_q;
    assign csr_write_data_o = wr_data_q;
    assign rsp_valid_o      = (state_q == StResp) && !pause_i;
    assign rd_we_o          = rsp_valid_o && !illegal_q && (rd_addr_q != 5'd0);
    assign rd_addr_o        = rd_addr_q;
    assign rd_data_o        = old_q;
    assign illegal_o        = (state_q == StResp) && illegal_q;
    assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  funct3_i = '0;
    logic [11:0] csr_addr_i = '0;
    logic [4:0]  rs1_addr_i = '0;
    logic [63:0] rs1_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        pause_i = 1'b0;
    logic        trap_enter_i = 1'b0;
    logic        csr_read_ena_o;
    logic [11:0] csr_read_addr_o;
    logic [63:0] csr_read_data_i = '0;
    logic        csr_write_ena_o;
    logic [11:0] csr_write_addr_o;
    logic [63:0] csr_write_data_o;
    logic        rsp_valid_o;
    logic        rd_we_o;
    logic [4:0]  rd_addr_o;
    logic [63:0] rd_data_o;
    logic        illegal_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    csr_access_unit #(.REG_WIDTH(64)) dut (
        .clk_sys_i        (clk),
        .rst_sys_i        (rst),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .funct3_i         (funct3_i),
        .csr_addr_i       (csr_addr_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs1_data_i       (rs1_data_i),
        .rd_addr_i        (rd_addr_i),
        .pause_i          (pause_i),
        .trap_enter_i     (trap_enter_i),
        .csr_read_ena_o   (csr_read_ena_o),
        .csr_read_addr_o  (csr_read_addr_o),
        .csr_read_data_i  (csr_read_data_i),
        .csr_write_ena_o  (csr_write_ena_o),
        .csr_write_addr_o (csr_write_addr_o),
        .csr_write_data_o (csr_write_data_o),
        .rsp_valid_o      (rsp_valid_o),
        .rd_we_o          (rd_we_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o),
        .illegal_o        (illegal_o),
        .busy_o           (busy_o)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] a;
        logic [4:0]  r1a;
        logic [63:0] r1d;
        logic [4:0]  rd;
        logic [63:0] cv;    // CSR content returned on read
        bit          rden;  // read strobe expected
        bit          wr;    // write expected
        logic [63:0] wd;
        bit          rdwe;
        logic [63:0] rdd;
        bit          ill;
        int          rsp;   // response cycle after accept
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level reference: what the architecture says the access does
    function automatic vec_t model(input logic [2:0] f3, input logic [11:0] a,
                                   input logic [4:0] r1a, input logic [63:0] r1d,
                                   input logic [4:0] rd, input logic [63:0] cv);
        vec_t e;
        logic [63:0] src;
        logic [63:0] old;
        bit rwop;
        bit wants;
        e.f3 = f3; e.a = a; e.r1a = r1a; e.r1d = r1d; e.rd = rd; e.cv = cv;
        rwop   = (f3 == 3'd1) || (f3 == 3'd5);
        src    = (f3 >= 3'd4) ? 64'(r1a) : r1d;
        e.rden = !(rwop && rd == 5'd0);
        old    = e.rden ? cv : 64'd0;
        wants  = rwop || ((f3 % 4) != 0 && r1a != 5'd0);
        e.ill  = ((f3 % 4) == 0) || (wants && a >= 12'hC00);
        e.wr   = wants && !e.ill;
        case (f3 % 4)
            1:       e.wd = src;
            2:       e.wd = old | src;
            3:       e.wd = old & ~src;
            default: e.wd = 64'd0;
        endcase
        e.rdwe = !e.ill && rd != 5'd0;
        e.rdd  = old;
        e.rsp  = e.wr ? 3 : 2;
        return e;
    endfunction

    task automatic drive_req(input vec_t v);
        req_valid_i     = 1'b1;
        funct3_i        = v.f3;
        csr_addr_i      = v.a;
        rs1_addr_i      = v.r1a;
        rs1_data_i      = v.r1d;
        rd_addr_i       = v.rd;
        csr_read_data_i = v.cv;
        pause_i         = 1'b0;
        trap_enter_i    = 1'b0;
    endtask

    // Called just after a negedge with the unit idle
    task automatic run_txn(input vec_t v, input bit rp, input bit timing, input string tag);
        int wr_cnt = 0;
        int wr_cyc = 0;
        int rsp_cyc = 0;
        bit rd_seen = 0;
        bit rsp_seen = 0;
        logic [11:0] wa = '0;
        logic [63:0] wd = '0;
        logic rdwe = 1'b0;
        logic ill = 1'b0;
        logic [63:0] rdd = '0;
        logic [4:0] rda = '0;
        drive_req(v);
        #1 chk({tag, " ready"}, 64'(req_ready_o), 64'd1);
        @(posedge clk);
        for (int c = 1; c <= 40 && !rsp_seen; c++) begin
            @(negedge clk);
            req_valid_i = 1'b0;
            pause_i = rp ? ($urandom_range(0, 2) == 0) : 1'b0;
            #1;
            if (csr_read_ena_o) begin
                if (!rd_seen) chk({tag, " rdaddr"}, 64'(csr_read_addr_o), 64'(v.a));
                rd_seen = 1;
            end
            if (csr_write_ena_o) begin
                wr_cnt++;
                wa = csr_write_addr_o;
                wd = csr_write_data_o;
                wr_cyc = c;
            end
            if (rsp_valid_o) begin
                rsp_seen = 1;
                rsp_cyc = c;
                rdwe = rd_we_o;
                rdd = rd_data_o;
                ill = illegal_o;
                rda = rd_addr_o;
            end
        end
        pause_i = 1'b0;
        chk({tag, " rsp_seen"}, 64'(rsp_seen), 64'd1);
        chk({tag, " wr_count"}, 64'(wr_cnt), 64'(v.wr));
        if (v.wr) begin
            chk({tag, " wr_addr"}, 64'(wa), 64'(v.a));
            chk({tag, " wr_data"}, wd, v.wd);
        end
        chk({tag, " rd_we"}, 64'(rdwe), 64'(v.rdwe));
        chk({tag, " rd_data"}, rdd, v.rdd);
        chk({tag, " illegal"}, 64'(ill), 64'(v.ill));
        chk({tag, " read_strobe"}, 64'(rd_seen), 64'(v.rden));
        if (v.rdwe) chk({tag, " rd_addr"}, 64'(rda), 64'(v.rd));
        if (timing) begin
            chk({tag, " rsp_cycle"}, 64'(rsp_cyc), 64'(v.rsp));
            if (v.wr) chk({tag, " wr_cycle"}, 64'(wr_cyc), 64'd2);
        end
        @(negedge clk);
        #1;
        chk({tag, " idle_after"}, 64'(busy_o), 64'd0);
        chk({tag, " rsp_single"}, 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        vec_t v;
        //          f3    addr      r1a    r1d             rd     cv                rden wr wd              rdwe rdd               ill rsp
        tbl[0] = '{3'd1, 12'h305, 5'd0,  64'h8000_0100, 5'd5, 64'h0,            1, 1, 64'h8000_0100, 1, 64'h0,            0, 3};
        tbl[1] = '{3'd2, 12'h300, 5'd0,  64'hFFFF,      5'd3, 64'hA_0000_0000,  1, 0, 64'h0,         1, 64'hA_0000_0000,  0, 2};
        tbl[2] = '{3'd7, 12'h304, 5'd8,  64'hFFFF,      5'd1, 64'h888,          1, 1, 64'h880,       1, 64'h888,          0, 3};
        tbl[3] = '{3'd5, 12'hF14, 5'd1,  64'h0,         5'd2, 64'h7,            1, 0, 64'h0,         0, 64'h7,            1, 2};
        tbl[4] = '{3'd1, 12'h340, 5'd9,  64'h1234,      5'd0, 64'hDEAD,         0, 1, 64'h1234,      0, 64'h0,            0, 3};
        tbl[5] = '{3'd0, 12'h300, 5'd3,  64'h1,         5'd6, 64'h55,           1, 0, 64'h0,         0, 64'h55,           1, 2};
        tbl[6] = '{3'd6, 12'h340, 5'd17, 64'h0,         5'd4, 64'h100,          1, 1, 64'h111,       1, 64'h100,          0, 3};
        tbl[7] = '{3'd3, 12'hC00, 5'd0,  64'hF,         5'd7, 64'h99,           1, 0, 64'h0,         1, 64'h99,           0, 2};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset ready", 64'(req_ready_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset wr_ena", 64'(csr_write_ena_o), 64'd0);
        chk("reset rsp", 64'(rsp_valid_o), 64'd0);
        chk("reset rd_data", rd_data_o, 64'd0);
        chk("reset wr_data", csr_write_data_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 chk("post-reset ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 8; i++) run_txn(tbl[i], 1'b0, 1'b1, $sformatf("tbl%0d", i));

        // Pause held for three cycles in WRITE
        v = tbl[0];
        v.r1d = 64'h1111; v.cv = 64'h22;
        drive_req(v);
        @(posedge clk);
        @(negedge clk); req_valid_i = 1'b0;
        #1 chk("pause read_strobe", 64'(csr_read_ena_o), 64'd1);
        @(negedge clk); pause_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            chk("pause wr_held", 64'(csr_write_ena_o), 64'd0);
            chk("pause rsp_held", 64'(rsp_valid_o), 64'd0);
        end
        @(negedge clk); pause_i = 1'b0;
        #1;
        chk("pause wr_release", 64'(csr_write_ena_o), 64'd1);
        chk("pause wr_data", csr_write_data_o, 64'h1111);
        @(negedge clk); #1;
        chk("pause rsp", 64'(rsp_valid_o), 64'd1);
        chk("pause no_dup_wr", 64'(csr_write_ena_o), 64'd0);
        chk("pause rd_data", rd_data_o, 64'h22);
        @(negedge clk); #1;
        chk("pause idle", 64'(busy_o), 64'd0);

        // Trap entry during READ aborts
        v = model(3'd2, 12'h300, 5'd4, 64'hF0, 5'd3, 64'h1);
        drive_req(v);
        @(posedge clk);
        @(negedge clk); req_valid_i = 1'b0; trap_enter_i = 1'b1;
        #1;
        chk("trap wr", 64'(csr_write_ena_o), 64'd0);
        chk("trap rsp", 64'(rsp_valid_o), 64'd0);
        chk("trap ready", 64'(req_ready_o), 64'd0);
        @(negedge clk); trap_enter_i = 1'b0;
        #1;
        chk("trap busy", 64'(busy_o), 64'd0);
        chk("trap rsp_after", 64'(rsp_valid_o), 64'd0);
        chk("trap ready_after", 64'(req_ready_o), 64'd1);
        @(negedge clk); #1;
        chk("trap no_wr_later", 64'(csr_write_ena_o), 64'd0);
        chk("trap no_rsp_later", 64'(rsp_valid_o), 64'd0);
        run_txn(tbl[2], 1'b0, 1'b1, "post-trap");

        // Reset mid-WRITE
        v = model(3'd1, 12'h305, 5'd2, 64'hABCD, 5'd5, 64'h3);
        drive_req(v);
        @(posedge clk);
        @(negedge clk); req_valid_i = 1'b0;
        @(negedge clk); #1;
        chk("rst_mid in_write", 64'(csr_write_ena_o), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid wr", 64'(csr_write_ena_o), 64'd0);
        chk("rst_mid busy", 64'(busy_o), 64'd0);
        chk("rst_mid ready", 64'(req_ready_o), 64'd0);
        chk("rst_mid wr_data", csr_write_data_o, 64'd0);
        chk("rst_mid wr_addr", 64'(csr_write_addr_o), 64'd0);
        chk("rst_mid rd_data", rd_data_o, 64'd0);
        @(negedge clk); rst = 1'b0;
        #1 chk("rst_mid ready_after", 64'(req_ready_o), 64'd1);
        run_txn(tbl[0], 1'b0, 1'b1, "post-rst");

        // Randomized accesses with random stalls
        for (int i = 0; i < 60; i++) begin
            logic [11:0] a;
            logic [4:0]  r1a;
            logic [4:0]  rd;
            a   = ($urandom_range(0, 3) == 0) ? {2'b11, 10'($urandom)} : 12'($urandom);
            r1a = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v = model(3'($urandom), a, r1a, {$urandom, $urandom}, rd, {$urandom, $urandom});
            run_txn(v, 1'b1, 1'b0, $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator side of the CSR read/write port: executes Zicsr instructions (CSRRW/RS/RC and the immediate forms) handed over by the execute stage.
- Sequences the read, computes the read-modify-write value, issues a single-cycle write to the CSR register file, and returns the old CSR value for rd write-back.
- Drops in-flight accesses when the register file signals trap entry.

Parameters:
REG_WIDTH, 64, data width of GPR/CSR values (RV64).

Ports:
clk_sys_i  input  1  system clock
rst_sys_i  input  1  reset; asynchronous, active-high
req_valid_i  input  1  CSR instruction valid from execute
req_ready_o  output  1  unit can accept a request this cycle
funct3_i  input  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
csr_addr_i  input  12  CSR address
rs1_addr_i  input  5  rs1 index, which is also uimm for the I-forms
rs1_data_i  input  REG_WIDTH  rs1 value
rd_addr_i  input  5  destination GPR index
pause_i  input  1  pipeline stall
trap_enter_i  input  1  trap entry from CSR register file
csr_read_ena_o  output  1  CSR read strobe
csr_read_addr_o  output  12  CSR read address
csr_read_data_i  input  REG_WIDTH  CSR read data (combinational return)
csr_write_ena_o  output  1  CSR write strobe
csr_write_addr_o  output  12  CSR write address
csr_write_data_o  output  REG_WIDTH  CSR write data
rsp_valid_o  output  1  one-cycle completion pulse
rd_we_o  output  1  write rd_data_o to GPR rd_addr_o
rd_addr_o  output  5  GPR index
rd_data_o  output  REG_WIDTH  old CSR value
illegal_o  output  1  illegal CSR access; valid with rsp_valid_o
busy_o  output  1  state != IDLE

Behaviour:
- Reset: state IDLE. Every output is 0, including req_ready_o, all data and address outputs, and all latched fields.
- States: IDLE, READ, WRITE, RESP.
- IDLE:
  - req_ready_o = !pause_i & !trap_enter_i.
  - On req_valid_i & req_ready_o, latch funct3, addr, rs1_addr, rs1_data, rd_addr, then go to READ.
- Source operand: src = funct3[2] ? zero-extended rs1_addr (uimm) : rs1_data.
- Read suppression: for RW/RWI with rd==0, csr_read_ena_o stays 0 and old = 0.
- Write suppression: for RS/RC/RSI/RCI with rs1_addr==0, no write is issued.
- Illegal access (no write, rd_we_o=0, illegal_o=1 in RESP):
  - funct3[1:0]==00, or
  - a write would be issued to addr[11:10]==2'b11 (read-only space).
- READ:
  - csr_read_ena_o=1 (unless suppressed); csr_read_addr_o = latched addr, combinational from state.
  - Sample csr_read_data_i into old at the clock edge, only when !pause_i.
  - Compute new value: RW → src; RS → old | src; RC → old & ~src. Width is REG_WIDTH, with no carries.
  - Register csr_write_addr_o/csr_write_data_o.
  - Next state is WRITE if a legal write is needed, else RESP.
- WRITE: csr_write_ena_o=1 (combinational from state, gated by !pause_i) for exactly one unpaused cycle, then go to RESP.
- RESP:
  - rsp_valid_o=1 for one cycle (gated by !pause_i).
  - rd_we_o = !illegal & rd!=0; rd_addr_o = rd; rd_data_o = old.
  - Then go to IDLE.
- Latency from accept edge:
  - With write: READ at +1, WRITE at +2, RESP at +3.
  - Without write: RESP at +2.
  - No back-to-back acceptance; the next accept is possible in the cycle after RESP.
- pause_i:
  - Holds the current state.
  - Forces csr_write_ena_o=0, rsp_valid_o=0 and rd_we_o=0.
  - Blocks sampling of old.
  - No duplicate write or response results from a paused cycle.
- trap_enter_i:
  - In READ or WRITE: abort. No write strobe that cycle, no response, next state IDLE, latched fields cleared.
  - In RESP: the write has already committed, so the response is still issued.
  - In IDLE: blocks acceptance.
  - Priority: trap_enter_i > pause_i > normal progress.
- Reset asserted mid-operation: state returns to IDLE immediately (asynchronous); all strobes deassert with no glitching write.
- Outputs outside their active state: csr_read_ena_o, csr_write_ena_o, rsp_valid_o, rd_we_o and illegal_o are 0.

Test Plan:
- CSRRW, mtvec=0x0, rs1_data=0x8000_0100, rd=5 → read strobe at +1, write of 0x8000_0100 to 0x305 at +2, rsp at +3 with rd_we=1, rd_data=0x0.
- CSRRS mstatus with rs1_addr=0 (x0), rd=3, mstatus=0xA_0000_0000 → no csr_write_ena_o; rsp at +2 with rd_data=0xA_0000_0000.
- CSRRCI mie, uimm=8, mie=0x888 → write data 0x880; CSRRWI to 0xF14 (mhartid) with uimm=1 → no write, illegal_o=1, rd_we_o=0.
- pause_i held for 3 cycles while in WRITE → exactly one csr_write_ena_o pulse after release; rsp one cycle later.
- trap_enter_i asserted in READ cycle → no write, no rsp_valid_o, busy_o=0 next cycle; a new request is accepted afterwards.
- rst_sys_i pulsed mid-WRITE → all outputs 0 asynchronously; after release, req_ready_o=1 and a CSRRW completes normally.
